// File: rtl/rx_word_packer_if.sv
// rtl/rx_word_packer_if.sv - byte strobe input and word valid/ready output bundle
interface rx_word_packer_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_err;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;

  modport slave (
    input  byte_in, byte_valid, byte_err, word_ready,
    output word_out, word_valid
  );

  modport master (
    output byte_in, byte_valid, byte_err, word_ready,
    input  word_out, word_valid
  );
endinterface

// File: rtl/rx_word_packer.sv
// rtl/rx_word_packer.sv - packs UART bytes into 32-bit words and queues them in a FWFT FIFO
module rx_word_packer #(
  parameter int DEPTH        = 4,
  parameter int TIMEOUT_CLKS = 0
) (
  input  logic               clk,
  input  logic               rst,
  rx_word_packer_if.slave    bus,
  input  logic               clear,
  output logic [1:0]         fill,
  output logic               full,
  output logic               overflow,
  output logic               timeout_seen,
  output logic [7:0]         err_cnt
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  logic [23:0] hold_q, hold_d;
  logic [1:0]  fill_q, fill_d;
  logic [31:0] tmo_q, tmo_d;
  ptr_t        wr_q, wr_d, rd_q, rd_d;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];
  logic        overflow_q, overflow_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  err_q, err_d;

  logic        push_req, push_ok, pop, empty, full_w, tmo_fire, err_byte;
  logic [31:0] push_word;

  assign empty     = (wr_q == rd_q);
  assign full_w    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign pop       = !empty && bus.word_ready;
  assign err_byte  = bus.byte_valid && bus.byte_err;

  assign bus.word_valid = !empty;
  assign bus.word_out   = mem_q[rd_q[AW-1:0]];
  assign fill           = fill_q;
  assign full           = full_w;
  assign overflow       = overflow_q;
  assign timeout_seen   = timeout_q;
  assign err_cnt        = err_q;

  // Packer: a strobed byte always beats a same-cycle timeout.
  always_comb begin
    hold_d    = hold_q;
    fill_d    = fill_q;
    push_req  = 1'b0;
    push_word = {bus.byte_in, hold_q};
    tmo_fire  = 1'b0;
    if (err_byte) begin
      fill_d = 2'd0;
    end else if (bus.byte_valid) begin
      case (fill_q)
        2'd0:    hold_d[7:0]   = bus.byte_in;
        2'd1:    hold_d[15:8]  = bus.byte_in;
        2'd2:    hold_d[23:16] = bus.byte_in;
        default: push_req      = 1'b1;
      endcase
      fill_d = fill_q + 2'd1;
    end else if (TIMEOUT_CLKS > 0 && fill_q != 2'd0 &&
                 tmo_q == 32'(TIMEOUT_CLKS - 1)) begin
      fill_d   = 2'd0;
      tmo_fire = 1'b1;
    end

    if (TIMEOUT_CLKS == 0 || bus.byte_valid || fill_q == 2'd0 || tmo_fire)
      tmo_d = 32'd0;
    else
      tmo_d = tmo_q + 32'd1;
  end

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  always_comb begin
    push_ok = push_req && (!full_w || pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    mem_d   = mem_q;
    if (push_ok) begin
      mem_d[wr_q[AW-1:0]] = push_word;
      wr_d                = wr_q + ptr_t'(1);
    end
    if (pop)
      rd_d = rd_q + ptr_t'(1);

    overflow_d = clear ? 1'b0 : (overflow_q || (push_req && !push_ok));
    timeout_d  = clear ? 1'b0 : (timeout_q || tmo_fire);
    if (clear)
      err_d = 8'd0;
    else if (err_byte && err_q != 8'hFF)
      err_d = err_q + 8'd1;
    else
      err_d = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q     <= '0;
      fill_q     <= '0;
      tmo_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      hold_q     <= hold_d;
      fill_q     <= fill_d;
      tmo_q      <= tmo_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_rx_word_packer.sv
// tb/tb_rx_word_packer.sv - directed scoreboard bench for rx_word_packer
module tb_rx_word_packer;
  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic [1:0] fill;
  logic       full, overflow, timeout_seen;
  logic [7:0] err_cnt;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  rx_word_packer_if bus();

  rx_word_packer #(.DEPTH(4), .TIMEOUT_CLKS(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .clear        (clear),
    .fill         (fill),
    .full         (full),
    .overflow     (overflow),
    .timeout_seen (timeout_seen),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Consumer side: each pop is checked against the oldest expected word.
  always @(negedge clk) begin
    if (!rst && bus.word_valid && bus.word_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_pop observed=0x%0h expected=none", bus.word_out);
      end else begin
        chk("word_out", bus.word_out, exp_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic e);
    bus.byte_in    = b;
    bus.byte_err   = e;
    bus.byte_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    bus.byte_err   = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit expect_push);
    if (expect_push)
      exp_q.push_back(w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] t;
      t = w >> (8 * i);
      send_byte(t[7:0], 1'b0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst            = 1'b1;
    clear          = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    bus.byte_err   = 1'b0;
    bus.word_ready = 1'b0;
    idle(3);
    chk("rst_word_out", bus.word_out, 32'h0);
    chk("rst_word_valid", 32'(bus.word_valid), 32'h0);
    chk("rst_fill", 32'(fill), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_flags", {29'h0, overflow, timeout_seen, 1'b0}, 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    rst = 1'b0;
    idle(1);

    // Basic packing, LSB first.
    bus.word_ready = 1'b1;
    exp_q.push_back(32'h44332211);
    send_byte(8'h11, 1'b0); chk("fill1", 32'(fill), 32'd1);
    send_byte(8'h22, 1'b0); chk("fill2", 32'(fill), 32'd2);
    send_byte(8'h33, 1'b0); chk("fill3", 32'(fill), 32'd3);
    send_byte(8'h44, 1'b0); chk("fill0", 32'(fill), 32'd0);
    chk("valid_after_word", 32'(bus.word_valid), 32'd1);
    idle(1);
    chk("valid_one_cycle", 32'(bus.word_valid), 32'd0);

    // Fill to full, then overflow on the fifth word.
    bus.word_ready = 1'b0;
    send_word(32'hA0A1A2A3, 1'b1);
    send_word(32'hB0B1B2B3, 1'b1);
    send_word(32'hC0C1C2C3, 1'b1);
    chk("not_full_3", 32'(full), 32'd0);
    send_word(32'hD0D1D2D3, 1'b1);
    chk("full_4", 32'(full), 32'd1);
    chk("no_ovf_4", 32'(overflow), 32'd0);
    send_word(32'hE0E1E2E3, 1'b0);
    chk("ovf_5", 32'(overflow), 32'd1);
    bus.word_ready = 1'b1;
    idle(5);
    chk("drained_valid", 32'(bus.word_valid), 32'd0);
    chk("drained_sb", 32'(exp_q.size()), 32'd0);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Push into a full FIFO in the same cycle as a pop.
    bus.word_ready = 1'b0;
    send_word(32'h01010101, 1'b1);
    send_word(32'h02020202, 1'b1);
    send_word(32'h03030303, 1'b1);
    send_word(32'h04040404, 1'b1);
    chk("full_before_pp", 32'(full), 32'd1);
    exp_q.push_back(32'h05050505);
    send_byte(8'h05, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h05, 1'b0);
    bus.word_ready = 1'b1;
    send_byte(8'h05, 1'b0);
    bus.word_ready = 1'b0;
    chk("pp_full", 32'(full), 32'd1);
    chk("pp_no_ovf", 32'(overflow), 32'd0);
    bus.word_ready = 1'b1;
    idle(5);
    chk("pp_drained", 32'(bus.word_valid), 32'd0);
    chk("pp_sb", 32'(exp_q.size()), 32'd0);

    // Error byte discards the partial word.
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'h5A, 1'b1);
    chk("err_fill", 32'(fill), 32'd0);
    chk("err_cnt1", 32'(err_cnt), 32'd1);
    send_word(32'h04030201, 1'b1);
    idle(2);
    chk("err_sb", 32'(exp_q.size()), 32'd0);
    chk("err_cnt_hold", 32'(err_cnt), 32'd1);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    chk("err_cleared", 32'(err_cnt), 32'd0);
    clear = 1'b1;
    send_byte(8'h77, 1'b1);
    clear = 1'b0;
    chk("clear_beats_err", 32'(err_cnt), 32'd0);

    // Timeout of a stalled partial word.
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    idle(15);
    chk("tmo_fill_15", 32'(fill), 32'd2);
    chk("tmo_flag_15", 32'(timeout_seen), 32'd0);
    idle(1);
    chk("tmo_fill_16", 32'(fill), 32'd0);
    chk("tmo_flag_16", 32'(timeout_seen), 32'd1);
    send_word(32'hDEADBEEF, 1'b1);
    idle(2);
    chk("tmo_sb", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-word with words queued.
    bus.word_ready = 1'b0;
    send_byte(8'h99, 1'b1);
    send_word(32'hA1A2A3A4, 1'b1);
    send_word(32'hB1B2B3B4, 1'b1);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    chk("pre_rst_fill", 32'(fill), 32'd2);
    chk("pre_rst_valid", 32'(bus.word_valid), 32'd1);
    chk("pre_rst_err", 32'(err_cnt), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_fill", 32'(fill), 32'd0);
    chk("arst_valid", 32'(bus.word_valid), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_flags", {30'h0, overflow, timeout_seen}, 32'h0);
    chk("arst_err", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    chk("post_rst_valid", 32'(bus.word_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
